// File: rtl/bids_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bids_pkg
//  Description : Shared opcode/state encodings and error codes for the
//                N-way auction controller.
//  Revision    : 1.0  initial release
// ============================================================================
package bids_pkg;

  // Host control opcodes; encodings 7..15 are invalid
  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_UNLOCK    = 4'd1,
    OP_LOCK      = 4'd2,
    OP_LOADBAL   = 4'd3,
    OP_SETMASK   = 4'd4,
    OP_SETTIMER  = 4'd5,
    OP_BIDCHARGE = 4'd6
  } op_e;

  // Controller states
  typedef enum logic [2:0] {
    ST_RESET        = 3'd0,
    ST_UNLOCKED     = 3'd1,
    ST_LOCKED       = 3'd2,
    ST_LOCKOUT      = 3'd3,
    ST_ROUND_ACTIVE = 3'd4,
    ST_ROUND_OVER   = 3'd5
  } state_e;

  // Controller error codes
  localparam logic [2:0] ERR_NONE             = 3'b000;
  localparam logic [2:0] ERR_BADKEY           = 3'b001;
  localparam logic [2:0] ERR_ALREADY_UNLOCKED = 3'b010;
  localparam logic [2:0] ERR_START_UNLOCKED   = 3'b011;
  localparam logic [2:0] ERR_INVALID          = 3'b100;

  // Per-bidder error codes
  localparam logic [1:0] BERR_OK       = 2'b00;
  localparam logic [1:0] BERR_INACTIVE = 2'b01;
  localparam logic [1:0] BERR_FUNDS    = 2'b10;
  localparam logic [1:0] BERR_INVALID  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/bids_lane.sv
`default_nettype none
// ============================================================================
//  Module      : bids_lane
//  Description : One bidder channel: available funds, bid total and charge
//                accounting for the current round, plus ack/error pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module bids_lane
  import bids_pkg::*;
#(
  parameter int BID_W = 16,
  parameter int BAL_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,     // round begins: reload from committed balance
  input  logic             eval,      // round active and c_start high
  input  logic             idle,      // controller not in ROUND_ACTIVE
  input  logic             enable,    // mask bit for this bidder
  input  logic             bid,
  input  logic             retract,
  input  logic [BID_W-1:0] amt,
  input  logic [BAL_W-1:0] cost,
  input  logic [BAL_W-1:0] bal,
  output logic [BAL_W-1:0] avail,
  output logic [BAL_W-1:0] total,
  output logic [BAL_W-1:0] charge,
  output logic             ack,
  output logic [1:0]       berr,
  output logic             conflict   // bid and retract together this cycle
);

  logic [BAL_W-1:0] avail_q, avail_d;
  logic [BAL_W-1:0] total_q, total_d;
  logic [BAL_W-1:0] charge_q, charge_d;
  logic             ack_q, ack_d;
  logic [1:0]       berr_q, berr_d;
  logic [BAL_W:0]   amt_x, avail_x, cost_x;

  // Request evaluation; one extra bit of headroom keeps the guards exact
  always_comb begin
    amt_x    = {{(BAL_W + 1 - BID_W){1'b0}}, amt};
    avail_x  = {1'b0, avail_q};
    cost_x   = {1'b0, cost};
    avail_d  = avail_q;
    total_d  = total_q;
    charge_d = charge_q;
    ack_d    = 1'b0;
    berr_d   = BERR_OK;
    conflict = 1'b0;
    if (start) begin
      avail_d  = bal;
      total_d  = '0;
      charge_d = '0;
    end
    if (eval) begin
      if (bid && retract) begin
        berr_d   = BERR_INVALID;
        conflict = 1'b1;
      end else if (!enable && (bid || retract)) begin
        berr_d = BERR_INVALID;
      end else if (bid) begin
        if (avail_x >= amt_x + cost_x) begin
          ack_d    = 1'b1;
          total_d  = total_q + amt_x[BAL_W-1:0];
          avail_d  = BAL_W'(avail_x - amt_x - cost_x);
          charge_d = charge_q + cost;
        end else begin
          berr_d = BERR_FUNDS;
        end
      end else if (retract) begin
        if (({1'b0, total_q} >= amt_x) && (avail_x + amt_x >= cost_x)) begin
          total_d  = total_q - amt_x[BAL_W-1:0];
          avail_d  = BAL_W'(avail_x + amt_x - cost_x);
          charge_d = charge_q + cost;
        end else begin
          berr_d = BERR_FUNDS;
        end
      end
    end else if (idle && bid) begin
      berr_d = BERR_INACTIVE;
    end
  end

  // Lane state and registered ack/error outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      avail_q  <= '0;
      total_q  <= '0;
      charge_q <= '0;
      ack_q    <= 1'b0;
      berr_q   <= BERR_OK;
    end else begin
      avail_q  <= avail_d;
      total_q  <= total_d;
      charge_q <= charge_d;
      ack_q    <= ack_d;
      berr_q   <= berr_d;
    end
  end

  assign avail  = avail_q;
  assign total  = total_q;
  assign charge = charge_q;
  assign ack    = ack_q;
  assign berr   = berr_q;

endmodule
`default_nettype wire

// File: rtl/bids_nway_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bids_nway_controller
//  Description : N-bidder auction controller: host command FSM with keyed
//                lock and timed lockout, per-bidder lanes, winner selection
//                and balance commit at round end.
//  Revision    : 1.0  initial release
// ============================================================================
module bids_nway_controller
  import bids_pkg::*;
#(
  parameter int NUM_BIDDERS = 3,
  parameter int BID_W       = 16,
  parameter int BAL_W       = 32,
  parameter int TIMER_W     = 4,
  parameter int IDX_W       = $clog2(NUM_BIDDERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_BIDDERS*BID_W-1:0] bid_amt,
  input  logic [NUM_BIDDERS-1:0]       bid,
  input  logic [NUM_BIDDERS-1:0]       retract,
  input  logic [BAL_W-1:0]             c_data,
  input  logic [IDX_W-1:0]             c_sel,
  input  logic [3:0]                   c_op,
  input  logic                         c_start,
  output logic [NUM_BIDDERS-1:0]       ack,
  output logic [2*NUM_BIDDERS-1:0]     bidder_err,
  output logic [NUM_BIDDERS*BAL_W-1:0] balance,
  output logic [NUM_BIDDERS-1:0]       win,
  output logic                         ready,
  output logic [2:0]                   err,
  output logic                         round_over,
  output logic [BAL_W-1:0]             max_bid
);

  state_e                  state_q, state_d;
  logic [BAL_W-1:0]        bal_q [NUM_BIDDERS];
  logic [BAL_W-1:0]        bal_d [NUM_BIDDERS];
  logic [NUM_BIDDERS-1:0]  mask_q, mask_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [TIMER_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [BAL_W-1:0]        key_q, key_d;
  logic [BAL_W-1:0]        cost_q, cost_d;
  logic [2:0]              err_q, err_d;
  logic [NUM_BIDDERS-1:0]  win_q, win_d;
  logic [BAL_W-1:0]        max_bid_q, max_bid_d;
  logic                    ready_q, ready_d;
  logic                    round_over_q, round_over_d;

  logic                    round_start, sel_hit;
  logic [BAL_W-1:0]        lane_avail  [NUM_BIDDERS];
  logic [BAL_W-1:0]        lane_total  [NUM_BIDDERS];
  logic [BAL_W-1:0]        lane_charge [NUM_BIDDERS];
  logic [NUM_BIDDERS-1:0]  lane_conflict;
  logic [NUM_BIDDERS-1:0]  best_win;
  logic [BAL_W-1:0]        best_total;
  logic [TIMER_W-1:0]      lock_load;

  generate
    for (genvar i = 0; i < NUM_BIDDERS; i++) begin : g_lane
      bids_lane #(.BID_W(BID_W), .BAL_W(BAL_W)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .start    (round_start),
        .eval     ((state_q == ST_ROUND_ACTIVE) && c_start),
        .idle     (state_q != ST_ROUND_ACTIVE),
        .enable   (mask_q[i]),
        .bid      (bid[i]),
        .retract  (retract[i]),
        .amt      (bid_amt[i*BID_W +: BID_W]),
        .cost     (cost_q),
        .bal      (bal_q[i]),
        .avail    (lane_avail[i]),
        .total    (lane_total[i]),
        .charge   (lane_charge[i]),
        .ack      (ack[i]),
        .berr     (bidder_err[2*i +: 2]),
        .conflict (lane_conflict[i])
      );
      assign balance[i*BAL_W +: BAL_W] = bal_q[i];
    end
  endgenerate

  // Winner select: strict compare keeps the lowest index on ties; all-zero totals give no winner
  always_comb begin
    best_total = '0;
    best_win   = '0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (lane_total[i] > best_total) begin
        best_total  = lane_total[i];
        best_win    = '0;
        best_win[i] = 1'b1;
      end
    end
  end

  // Lockout lasts max(timer,1) cycles; counter holds cycles remaining after the first
  assign lock_load = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);

  // Command FSM, config registers and round-end commit
  always_comb begin
    state_d     = state_q;
    bal_d       = bal_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    key_d       = key_q;
    cost_d      = cost_q;
    lock_cnt_d  = lock_cnt_q;
    err_d       = ERR_NONE;
    win_d       = win_q;
    max_bid_d   = max_bid_q;
    round_start = 1'b0;
    sel_hit     = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_UNLOCKED;
      ST_UNLOCKED: begin
        case (c_op)
          OP_NOP:       ;
          OP_UNLOCK:    err_d = ERR_ALREADY_UNLOCKED;
          OP_LOCK: begin
            key_d   = c_data;
            state_d = ST_LOCKED;
          end
          OP_LOADBAL: begin
            for (int i = 0; i < NUM_BIDDERS; i++) begin
              if (c_sel == IDX_W'(i)) begin
                bal_d[i] = c_data;
                sel_hit  = 1'b1;
              end
            end
            if (!sel_hit) err_d = ERR_INVALID;
          end
          OP_SETMASK:   mask_d  = c_data[NUM_BIDDERS-1:0];
          OP_SETTIMER:  timer_d = c_data[TIMER_W-1:0];
          OP_BIDCHARGE: cost_d  = c_data;
          default:      err_d   = ERR_INVALID;
        endcase
        if (c_start) err_d = ERR_START_UNLOCKED;
      end
      ST_LOCKED, ST_ROUND_OVER: begin
        if (c_start) begin
          state_d     = ST_ROUND_ACTIVE;
          round_start = 1'b1;
        end else if (c_op == OP_UNLOCK) begin
          if (c_data == key_q) begin
            state_d = ST_UNLOCKED;
          end else begin
            state_d    = ST_LOCKOUT;
            err_d      = ERR_BADKEY;
            lock_cnt_d = lock_load;
          end
        end else if (c_op != OP_NOP) begin
          state_d = ST_LOCKED;
          err_d   = ERR_INVALID;
        end
      end
      ST_LOCKOUT: begin
        err_d = err_q;
        if (lock_cnt_q == '0) begin
          state_d = ST_LOCKED;
          err_d   = ERR_NONE;
        end else begin
          lock_cnt_d = lock_cnt_q - TIMER_W'(1);
        end
      end
      ST_ROUND_ACTIVE: begin
        if (!c_start) begin
          state_d   = ST_ROUND_OVER;
          win_d     = best_win;
          max_bid_d = best_total;
          for (int i = 0; i < NUM_BIDDERS; i++) begin
            bal_d[i] = best_win[i] ? lane_avail[i] : bal_q[i] - lane_charge[i];
          end
        end else if (|lane_conflict) begin
          err_d = ERR_INVALID;
        end
      end
      default: state_d = ST_RESET;
    endcase
    if (state_d != ST_ROUND_OVER) begin
      win_d     = '0;
      max_bid_d = '0;
    end
    ready_d      = (state_d == ST_UNLOCKED) || (state_d == ST_LOCKED) ||
                   (state_d == ST_ROUND_OVER);
    round_over_d = (state_d == ST_ROUND_OVER);
  end

  // State and output registers; reset discards any round in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      bal_q        <= '{default: '0};
      mask_q       <= '1;
      timer_q      <= '1;
      key_q        <= '0;
      cost_q       <= BAL_W'(1);
      lock_cnt_q   <= '0;
      err_q        <= ERR_NONE;
      win_q        <= '0;
      max_bid_q    <= '0;
      ready_q      <= 1'b0;
      round_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bal_q        <= bal_d;
      mask_q       <= mask_d;
      timer_q      <= timer_d;
      key_q        <= key_d;
      cost_q       <= cost_d;
      lock_cnt_q   <= lock_cnt_d;
      err_q        <= err_d;
      win_q        <= win_d;
      max_bid_q    <= max_bid_d;
      ready_q      <= ready_d;
      round_over_q <= round_over_d;
    end
  end

  assign win        = win_q;
  assign ready      = ready_q;
  assign err        = err_q;
  assign round_over = round_over_q;
  assign max_bid    = max_bid_q;

endmodule
`default_nettype wire

// File: tb/tb_bids_nway_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bids_nway_controller
//  Description : Self-checking bench for bids_nway_controller (3 bidders).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bids_nway_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] bid_amt;
  logic [2:0]  bid, retract;
  logic [31:0] c_data;
  logic [1:0]  c_sel;
  logic [3:0]  c_op;
  logic        c_start;
  logic [2:0]  ack;
  logic [5:0]  bidder_err;
  logic [95:0] balance;
  logic [2:0]  win;
  logic        ready;
  logic [2:0]  err;
  logic        round_over;
  logic [31:0] max_bid;

  int n_cmp = 0;
  int n_bad = 0;

  bids_nway_controller dut (
    .clk(clk), .reset(reset), .bid_amt(bid_amt), .bid(bid), .retract(retract),
    .c_data(c_data), .c_sel(c_sel), .c_op(c_op), .c_start(c_start),
    .ack(ack), .bidder_err(bidder_err), .balance(balance), .win(win),
    .ready(ready), .err(err), .round_over(round_over), .max_bid(max_bid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [31:0] data;
    logic [1:0]  sel;
    logic        st;
    logic [2:0]  bd;
    logic [15:0] amt0;
    logic        rdy;
    logic [2:0]  er;
    logic [2:0]  ak;
    logic [5:0]  be;
    logic        ro;
    logic [2:0]  wn;
    logic [31:0] mb;
    logic [31:0] b0;
  } vec_t;

  vec_t tv[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setc(input logic [3:0] op, input logic [31:0] d, input logic [1:0] s, input logic st);
    c_op = op; c_data = d; c_sel = s; c_start = st;
    bid = '0; retract = '0; bid_amt = '0;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; setc(4'd0, 0, 0, 1'b0); tick();
    reset = 1'b0; tick();
  endtask

  // reference model state
  longint mbal[3], mav[3], mtot[3], mch[3];
  longint cost, mx;
  int     sel, a, code, wi;
  logic [2:0] mask, eak, eer, ewin;
  logic [5:0] ebe;

  initial begin
    reset = 1'b0;
    setc(4'd0, 0, 0, 1'b0);

    // ---------------- table-driven basic flow ----------------
    //        rst op     data      sel  st  bd    amt   rdy er      ak    be       ro  wn    mb  b0
    tv[0]  = '{1, 4'd0, 32'd0,    2'd0, 0, 3'b0, 16'd0,  0, 3'b000, 3'b0, 6'b0,     0, 3'b0,  0, 0};
    tv[1]  = '{0, 4'd0, 32'd0,    2'd0, 0, 3'b0, 16'd0,  1, 3'b000, 3'b0, 6'b0,     0, 3'b0,  0, 0};
    tv[2]  = '{0, 4'd3, 32'd100,  2'd0, 0, 3'b0, 16'd0,  1, 3'b000, 3'b0, 6'b0,     0, 3'b0,  0, 100};
    tv[3]  = '{0, 4'd2, 32'hA5,   2'd0, 0, 3'b0, 16'd0,  1, 3'b000, 3'b0, 6'b0,     0, 3'b0,  0, 100};
    tv[4]  = '{0, 4'd0, 32'd0,    2'd0, 1, 3'b0, 16'd0,  0, 3'b000, 3'b0, 6'b0,     0, 3'b0,  0, 100};
    tv[5]  = '{0, 4'd0, 32'd0,    2'd0, 1, 3'b1, 16'd20, 0, 3'b000, 3'b1, 6'b0,     0, 3'b0,  0, 100};
    tv[6]  = '{0, 4'd0, 32'd0,    2'd0, 0, 3'b0, 16'd0,  1, 3'b000, 3'b0, 6'b0,     1, 3'b1, 20, 79};
    tv[7]  = '{0, 4'd0, 32'd0,    2'd0, 0, 3'b0, 16'd0,  1, 3'b000, 3'b0, 6'b0,     1, 3'b1, 20, 79};
    tv[8]  = '{0, 4'd1, 32'hA5,   2'd0, 0, 3'b0, 16'd0,  1, 3'b000, 3'b0, 6'b0,     0, 3'b0,  0, 79};
    tv[9]  = '{0, 4'd1, 32'd0,    2'd0, 1, 3'b0, 16'd0,  1, 3'b011, 3'b0, 6'b0,     0, 3'b0,  0, 79};
    tv[10] = '{0, 4'd7, 32'd0,    2'd0, 0, 3'b0, 16'd0,  1, 3'b100, 3'b0, 6'b0,     0, 3'b0,  0, 79};
    tv[11] = '{0, 4'd1, 32'd0,    2'd0, 0, 3'b0, 16'd0,  1, 3'b010, 3'b0, 6'b0,     0, 3'b0,  0, 79};
    tv[12] = '{0, 4'd0, 32'd0,    2'd0, 0, 3'b1, 16'd5,  1, 3'b000, 3'b0, 6'b000001, 0, 3'b0, 0, 79};
    tv[13] = '{0, 4'd3, 32'd5,    2'd3, 0, 3'b0, 16'd0,  1, 3'b100, 3'b0, 6'b0,     0, 3'b0,  0, 79};

    for (int v = 0; v < 14; v++) begin
      reset = tv[v].rst;
      setc(tv[v].op, tv[v].data, tv[v].sel, tv[v].st);
      bid = tv[v].bd;
      bid_amt = {32'd0, tv[v].amt0};
      tick();
      chk($sformatf("v%0d ready", v), ready, tv[v].rdy);
      chk($sformatf("v%0d err", v), err, tv[v].er);
      chk($sformatf("v%0d ack", v), ack, tv[v].ak);
      chk($sformatf("v%0d bidder_err", v), bidder_err, tv[v].be);
      chk($sformatf("v%0d round_over", v), round_over, tv[v].ro);
      chk($sformatf("v%0d win", v), win, tv[v].wn);
      chk($sformatf("v%0d max_bid", v), max_bid, tv[v].mb);
      chk($sformatf("v%0d balance0", v), balance[31:0], tv[v].b0);
    end

    // ---------------- tie: lowest index wins ----------------
    do_reset();
    setc(4'd3, 32'd50, 2'd1, 1'b0); tick();
    setc(4'd3, 32'd50, 2'd2, 1'b0); tick();
    setc(4'd2, 32'hA5, 2'd0, 1'b0); tick();
    setc(4'd0, 0, 0, 1'b1); tick();
    setc(4'd0, 0, 0, 1'b1); bid = 3'b110; bid_amt = {16'd30, 16'd30, 16'd0}; tick();
    chk("tie ack", ack, 3'b110);
    setc(4'd0, 0, 0, 1'b0); tick();
    chk("tie win", win, 3'b010);
    chk("tie max_bid", max_bid, 32'd30);
    chk("tie balance1", balance[63:32], 32'd19);
    chk("tie balance2", balance[95:64], 32'd49);

    // ---------------- insufficient funds boundary ----------------
    do_reset();
    setc(4'd3, 32'd10, 2'd0, 1'b0); tick();
    setc(4'd2, 32'hA5, 2'd0, 1'b0); tick();
    setc(4'd0, 0, 0, 1'b1); tick();
    setc(4'd0, 0, 0, 1'b1); bid = 3'b001; bid_amt = {32'd0, 16'd10}; tick();
    chk("funds bidder_err", bidder_err, 6'b000010);
    chk("funds ack", ack, 3'b000);
    setc(4'd0, 0, 0, 1'b0); tick();
    chk("funds win", win, 3'b000);
    chk("funds max_bid", max_bid, 32'd0);
    chk("funds balance0", balance[31:0], 32'd10);

    // ---------------- lockout with timer 3 ----------------
    do_reset();
    setc(4'd5, 32'd3, 0, 1'b0); tick();
    setc(4'd2, 32'hA5, 0, 1'b0); tick();
    setc(4'd1, 32'h00, 0, 1'b0); tick();
    chk("lockout c1 err", err, 3'b001);
    chk("lockout c1 ready", ready, 1'b0);
    setc(4'd0, 0, 0, 1'b0); tick();
    chk("lockout c2 ready", ready, 1'b0);
    setc(4'd1, 32'hA5, 0, 1'b1); tick();
    chk("lockout c3 ready", ready, 1'b0);
    setc(4'd0, 0, 0, 1'b0); tick();
    chk("lockout end ready", ready, 1'b1);
    chk("lockout end err", err, 3'b000);
    setc(4'd1, 32'hA5, 0, 1'b0); tick();
    chk("unlock good err", err, 3'b000);
    setc(4'd1, 32'h0, 0, 1'b0); tick();
    chk("now unlocked err", err, 3'b010);

    // ---------------- lockout with timer 0 lasts one cycle ----------------
    setc(4'd5, 32'd0, 0, 1'b0); tick();
    setc(4'd2, 32'h11, 0, 1'b0); tick();
    setc(4'd1, 32'h12, 0, 1'b0); tick();
    chk("t0 lockout ready", ready, 1'b0);
    setc(4'd0, 0, 0, 1'b0); tick();
    chk("t0 back ready", ready, 1'b1);

    // ---------------- mask and bid+retract conflict ----------------
    do_reset();
    setc(4'd3, 32'd100, 2'd0, 1'b0); tick();
    setc(4'd3, 32'd100, 2'd1, 1'b0); tick();
    setc(4'd4, 32'b110, 0, 1'b0); tick();
    setc(4'd2, 32'hA5, 0, 1'b0); tick();
    setc(4'd0, 0, 0, 1'b1); tick();
    setc(4'd0, 0, 0, 1'b1); bid = 3'b001; bid_amt = {32'd0, 16'd5}; tick();
    chk("mask bidder_err", bidder_err, 6'b000011);
    chk("mask ack", ack, 3'b000);
    setc(4'd0, 0, 0, 1'b1); bid = 3'b010; retract = 3'b010; bid_amt = {16'd0, 16'd5, 16'd0}; tick();
    chk("conflict bidder_err", bidder_err, 6'b001100);
    chk("conflict err", err, 3'b100);

    // ---------------- reset mid-round ----------------
    setc(4'd0, 0, 0, 1'b1); bid = 3'b010; bid_amt = {16'd0, 16'd5, 16'd0};
    reset = 1'b1; tick();
    chk("midreset ack", ack, 3'b000);
    chk("midreset bidder_err", bidder_err, 6'b0);
    chk("midreset ready", ready, 1'b0);
    chk("midreset balance", balance, 96'd0);
    chk("midreset misc", {err, round_over, win, max_bid}, 39'd0);
    reset = 1'b0; setc(4'd0, 0, 0, 1'b0); tick();
    chk("after reset ready", ready, 1'b1);

    // ---------------- randomized rounds vs reference model ----------------
    for (int r = 0; r < 25; r++) begin
      do_reset();
      for (int i = 0; i < 3; i++) begin
        mbal[i] = longint'($urandom_range(0, 150));
        setc(4'd3, 32'(mbal[i]), 2'(i), 1'b0); tick();
      end
      cost = longint'($urandom_range(0, 3));
      setc(4'd6, 32'(cost), 0, 1'b0); tick();
      mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      setc(4'd4, {29'd0, mask}, 0, 1'b0); tick();
      setc(4'd2, 32'h5A, 0, 1'b0); tick();
      setc(4'd0, 0, 0, 1'b1); tick();
      for (int i = 0; i < 3; i++) begin
        mav[i] = mbal[i]; mtot[i] = 0; mch[i] = 0;
      end
      for (int k = 0; k < 20; k++) begin
        setc(4'd0, 0, 0, 1'b1);
        eak = '0; ebe = '0; eer = '0;
        for (int i = 0; i < 3; i++) begin
          sel = int'($urandom_range(0, 19));
          a   = int'($urandom_range(0, 40));
          bid[i]     = (sel < 10) || (sel == 19);
          retract[i] = (sel >= 10 && sel < 17) || (sel == 19);
          bid_amt[i*16 +: 16] = 16'(a);
          code = 0;
          if (bid[i] && retract[i]) begin
            code = 3; eer = 3'b100;
          end else if (!mask[i] && (bid[i] || retract[i])) begin
            code = 3;
          end else if (bid[i]) begin
            if (mav[i] >= a + cost) begin
              eak[i] = 1'b1; mtot[i] += a; mav[i] -= a + cost; mch[i] += cost;
            end else code = 2;
          end else if (retract[i]) begin
            if (mtot[i] >= a && mav[i] + a >= cost) begin
              mtot[i] -= a; mav[i] += a - cost; mch[i] += cost;
            end else code = 2;
          end
          ebe[2*i +: 2] = 2'(code);
        end
        tick();
        chk($sformatf("rnd%0d.%0d ack", r, k), ack, eak);
        chk($sformatf("rnd%0d.%0d bidder_err", r, k), bidder_err, ebe);
        chk($sformatf("rnd%0d.%0d err", r, k), err, eer);
      end
      // round end: highest total, first index among equals
      mx = 0;
      for (int i = 0; i < 3; i++) if (mtot[i] > mx) mx = mtot[i];
      wi = -1;
      for (int i = 2; i >= 0; i--) if (mx > 0 && mtot[i] == mx) wi = i;
      ewin = '0;
      for (int i = 0; i < 3; i++) begin
        if (i == wi) begin
          ewin[i] = 1'b1; mbal[i] = mav[i];
        end else begin
          mbal[i] = mbal[i] - mch[i];
        end
      end
      setc(4'd0, 0, 0, 1'b0); tick();
      chk($sformatf("rnd%0d round_over", r), round_over, 1'b1);
      chk($sformatf("rnd%0d win", r), win, ewin);
      chk($sformatf("rnd%0d max_bid", r), max_bid, 32'(mx));
      chk($sformatf("rnd%0d balance", r), balance, {32'(mbal[2]), 32'(mbal[1]), 32'(mbal[0])});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
